xdma_batch_scheduler: RTL

// - Sequences host readout of DDR batches produced by the DDR address allocator.
// - Queues batch descriptors {addr,len} and presents them one at a time to the BAR register file.
// - Raises the host interrupt and retries it on timeout; tracks outstanding (unread) DDR bytes.
// - Asserts allocator backpressure when the outstanding byte count reaches a high watermark.

---
 rtl/mm_pkg.sv | 10 +
 rtl/desc_fifo.sv | 50 +++++
 rtl/xdma_batch_scheduler.sv | 114 +++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// mm_pkg: shared FSM state encoding and bus widths for the batch scheduler.
package mm_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, IRQ, GAP, WAIT_DONE} state_t;

    localparam int DDR_BYTES = 1073741824;
    localparam int ADDR_W    = 32;
    localparam int LEN_W     = 32;

endpackage

// File: rtl/desc_fifo.sv
// desc_fifo: first-word-fall-through descriptor FIFO; head word visible on o_data while not empty.
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_push, i_data      write strobe and word (caller guarantees room, or a same-cycle pop)
//   i_pop               consume the head word
//   o_data              head word
//   o_full, o_empty     occupancy flags
//   o_level             current occupancy
module desc_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    count;

    always_ff @(posedge i_clk) begin
        if (i_push) mem[wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(i_push);
            rd_ptr <= rd_ptr + AW'(i_pop);
            count  <= count + LW'(i_push) - LW'(i_pop);
        end
    end

    assign o_data  = mem[rd_ptr];
    assign o_full  = count == LW'(DEPTH);
    assign o_empty = count == '0;
    assign o_level = count;

endmodule

// File: rtl/xdma_batch_scheduler.sv
// xdma_batch_scheduler: queues DDR batch descriptors, hands them one at a time to the BAR
// register file, raises/retries the host interrupt and tracks outstanding bytes.
//   i_clk, i_rst_n                         clock, asynchronous active-low reset
//   i_desc_addr/len/valid                  descriptor strobe from the allocator (cannot stall)
//   o_desc_drop, i_clr_err                 sticky overflow flag and its clear
//   o_bar_w_addr/len/valid                 1-cycle descriptor load into the BAR file
//   o_interrupt_req, i_interrupt_ack       level interrupt handshake with the XDMA core
//   i_host_done                            host finished reading the current batch
//   o_alloc_stall                          outstanding bytes at or above HIGH_WM
//   o_err_timeout                          pulse when a batch is abandoned after MAX_RETRY
//   o_fifo_level, o_outstanding_bytes      status
module xdma_batch_scheduler
    import mm_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int HIGH_WM     = 1073737728,
    parameter int IRQ_TIMEOUT = 10000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [ADDR_W-1:0]      i_desc_addr,
    input  logic [LEN_W-1:0]       i_desc_len,
    input  logic                   i_desc_valid,
    output logic                   o_desc_drop,
    output logic [ADDR_W-1:0]      o_bar_w_addr,
    output logic [LEN_W-1:0]       o_bar_w_len,
    output logic                   o_bar_w_valid,
    output logic                   o_interrupt_req,
    input  logic                   i_interrupt_ack,
    input  logic                   i_host_done,
    input  logic                   i_clr_err,
    output logic                   o_alloc_stall,
    output logic                   o_err_timeout,
    output logic [$clog2(DEPTH):0] o_fifo_level,
    output logic [31:0]            o_outstanding_bytes
);
    state_t state, state_n;
    logic [ADDR_W+LEN_W-1:0] head;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0] cur_len;
    logic [31:0] timer, outstanding;
    logic [7:0] retry;
    logic full, empty, pop, push, rel, abandon, timeout, offered;

    assign offered = i_desc_valid && i_desc_len != '0;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push    = offered && (!full || pop);
    assign timeout = timer == 32'(IRQ_TIMEOUT - 1);

    desc_fifo #(.DEPTH(DEPTH), .WIDTH(ADDR_W + LEN_W)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_pop   (pop),
        .i_data  ({i_desc_addr, i_desc_len}),
        .o_data  (head),
        .o_full  (full),
        .o_empty (empty),
        .o_level (o_fifo_level)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_n;
    end

    // Host done outranks ack, and ack outranks the timeout.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        rel     = 1'b0;
        abandon = 1'b0;
        case (state)
            IDLE:      if (!empty) begin pop = 1'b1; state_n = LOAD; end
            LOAD:      state_n = IRQ;
            IRQ:       if (i_host_done) begin rel = 1'b1; state_n = IDLE; end
                       else if (i_interrupt_ack) state_n = WAIT_DONE;
                       else if (timeout && retry < 8'(MAX_RETRY)) state_n = GAP;
                       else if (timeout) begin abandon = 1'b1; rel = 1'b1; state_n = IDLE; end
            GAP:       state_n = IRQ;
            WAIT_DONE: if (i_host_done) begin rel = 1'b1; state_n = IDLE; end
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            timer         <= '0;
            retry         <= '0;
            cur_addr      <= '0;
            cur_len       <= '0;
            outstanding   <= '0;
            o_alloc_stall <= 1'b0;
            o_desc_drop   <= 1'b0;
            o_err_timeout <= 1'b0;
        end else begin
            timer         <= (state == IRQ && state_n == IRQ) ? timer + 32'd1 : '0;
            retry         <= rel ? '0 : (state == IRQ && state_n == GAP) ? retry + 8'd1 : retry;
            if (pop) {cur_addr, cur_len} <= head;
            outstanding   <= outstanding + (push ? i_desc_len : '0) - (rel ? cur_len : '0);
            o_alloc_stall <= outstanding >= 32'(HIGH_WM);
            o_desc_drop   <= (offered && full && !pop) || (o_desc_drop && !i_clr_err);
            o_err_timeout <= abandon;
        end
    end

    assign o_bar_w_valid       = state == LOAD;
    assign o_bar_w_addr        = o_bar_w_valid ? cur_addr : '0;
    assign o_bar_w_len         = o_bar_w_valid ? cur_len : '0;
    assign o_interrupt_req     = state == IRQ;
    assign o_outstanding_bytes = outstanding;

endmodule
